// File: rtl/slow_window_ctl.sv
// Slow-device window controller: raises SlowReq/ClockGate on CPU accesses to
// slow device classes and holds them for SlowTimeout x TICK_DIV clocks afterwards.
module slow_window_ctl #(
    parameter int TICK_DIV = 256
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndBusy,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       SlowReq,
    output logic       ClockGate,
    output logic       SlowActive
);

    localparam int PreW = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
    localparam logic [PreW-1:0] PreOne = PreW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        HOLD = 2'd2
    } stateE;

    stateE           state;
    stateE           nextState;
    logic            bactR;
    logic [3:0]      cnt;
    logic [3:0]      nextCnt;
    logic [PreW-1:0] pre;
    logic [PreW-1:0] nextPre;
    logic            start;
    logic            hit;
    logic            nextBusy;

    assign start = BACT & ~bactR;
    assign hit   = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                   (SCCCS & SlowSCC) | (SCSICS & SlowSCSI);
    assign nextBusy = (nextState != IDLE);

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextPre   = pre;
        case (state)
            IDLE: begin
                if (start && hit) nextState = SLOW;
            end
            SLOW: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        nextState = IDLE;
                    end else begin
                        nextState = HOLD;
                        nextCnt   = SlowTimeout;
                        nextPre   = PreMax;
                    end
                end
            end
            HOLD: begin
                // A fresh hit abandons the remaining window outright.
                if (start && hit) begin
                    nextState = SLOW;
                end else if (pre != '0) begin
                    nextPre = pre - PreOne;
                end else if (cnt == 4'd1) begin
                    nextState = IDLE;
                end else begin
                    nextCnt = cnt - 4'd1;
                    nextPre = PreMax;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they move with the FSM.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state      <= IDLE;
            bactR      <= 1'b0;
            cnt        <= 4'd0;
            pre        <= '0;
            SlowReq    <= 1'b0;
            ClockGate  <= 1'b0;
            SlowActive <= 1'b0;
        end else begin
            state      <= nextState;
            bactR      <= BACT;
            cnt        <= nextCnt;
            pre        <= nextPre;
            SlowActive <= nextBusy;
            SlowReq    <= nextBusy | (SndBusy & SlowSnd);
            ClockGate  <= nextBusy & SlowClockGate;
        end
    end

endmodule

// File: tb/tb_slow_window_ctl.sv
// Directed bench for slow_window_ctl with TICK_DIV = 4: vector table plus
// hand-written sequences for asynchronous reset and re-hit during the hold window.
module tb_slow_window_ctl;

  localparam int TICK = 4;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       BACT;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS;
  logic       SndBusy;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowReq, ClockGate, SlowActive;

  slow_window_ctl #(.TICK_DIV(TICK)) dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
    .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS),
    .SndBusy(SndBusy),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
    .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
    .SlowTimeout(SlowTimeout),
    .SlowReq(SlowReq), .ClockGate(ClockGate), .SlowActive(SlowActive)
  );

  always #5 CLK = ~CLK;

  // cs = {IACK,VIA,IWM,SCC,SCSI}; en = {IACK,VIA,IWM,SCC,SCSI,Snd,ClockGate}
  // exp = {SlowReq,ClockGate,SlowActive} after the edge that consumes the inputs
  typedef struct {
    logic       bact;
    logic [4:0] cs;
    logic       snd_busy;
    logic [6:0] en;
    logic [3:0] timeout;
    logic [2:0] exp;
    string      name;
  } vec_t;

  vec_t vec_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic bact, input logic [4:0] cs, input logic snd,
                     input logic [6:0] en, input logic [3:0] to,
                     input logic [2:0] exp, input string nm);
    vec_t v;
    v.bact = bact; v.cs = cs; v.snd_busy = snd; v.en = en;
    v.timeout = to; v.exp = exp; v.name = nm;
    vec_q.push_back(v);
  endtask

  task automatic drive(input logic bact, input logic [4:0] cs, input logic snd,
                       input logic [6:0] en, input logic [3:0] to);
    BACT = bact;
    {IACKCS, VIACS, IWMCS, SCCCS, SCSICS} = cs;
    SndBusy = snd;
    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate} = en;
    SlowTimeout = to;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {req,gate,active}=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] outs();
    return {SlowReq, ClockGate, SlowActive};
  endfunction

  // Hit, drop into a 2-unit hold, re-hit 5 cycles in; the second hold uses to2.
  task automatic rehit(input logic [3:0] to2, input string nm);
    int  n;
    logic gap;
    gap = 1'b0;
    drive(1'b1, 5'b00100, 1'b0, 7'b0010000, 4'd2);
    tick(); gap |= ~SlowReq;
    tick(); gap |= ~SlowReq;
    drive(1'b0, 5'b00000, 1'b0, 7'b0010000, 4'd2);
    tick(); gap |= ~SlowReq;
    SlowTimeout = to2;
    for (int i = 0; i < 4; i++) begin
      tick(); gap |= ~SlowReq;
    end
    drive(1'b1, 5'b00100, 1'b0, 7'b0010000, to2);
    tick(); gap |= ~SlowReq;
    check({nm, "_reslow"}, outs(), 3'b101);
    tick(); gap |= ~SlowReq;
    drive(1'b0, 5'b00000, 1'b0, 7'b0010000, to2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!SlowReq) break;
      n++;
    end
    check({nm, "_nogap"}, {2'b00, gap}, 3'b000);
    check({nm, "_hold_len"}, 3'(n), 3'(int'(to2) * TICK));
    check({nm, "_idle"}, outs(), 3'b000);
  endtask

  initial begin
    nPOR = 1'b0;
    drive(1'b0, 5'b00000, 1'b0, 7'b0000000, 4'd0);
    tick();
    tick();
    check("reset", outs(), 3'b000);
    #3 nPOR = 1'b1;

    // Table: VIA hit, non-hit SCC, zero timeout, clock gate with a non-hit mid-hold, sound.
    add(0, 5'b00000, 0, 7'b0000000, 4'd0, 3'b000, "idle");
    for (int i = 0; i < 5; i++)  add(1, 5'b01000, 0, 7'b0100000, 4'd3, 3'b101, "via_slow");
    for (int i = 0; i < 12; i++) add(0, 5'b00000, 0, 7'b0100000, 4'd3, 3'b101, "via_hold");
    add(0, 5'b00000, 0, 7'b0100000, 4'd3, 3'b000, "via_end");
    for (int i = 0; i < 3; i++)  add(1, 5'b00010, 0, 7'b1110111, 4'd3, 3'b000, "scc_nohit");
    for (int i = 0; i < 2; i++)  add(0, 5'b00000, 0, 7'b1110111, 4'd3, 3'b000, "scc_after");
    for (int i = 0; i < 3; i++)  add(1, 5'b00100, 0, 7'b0010000, 4'd0, 3'b101, "iwm_slow");
    add(0, 5'b00000, 0, 7'b0010000, 4'd0, 3'b000, "iwm_t0_end");
    for (int i = 0; i < 2; i++)  add(1, 5'b00001, 0, 7'b0000101, 4'd1, 3'b111, "scsi_slow");
    add(0, 5'b00000, 0, 7'b0000101, 4'd1, 3'b111, "scsi_hold");
    for (int i = 0; i < 2; i++)  add(1, 5'b00010, 0, 7'b0000101, 4'd1, 3'b111, "hold_nonhit");
    add(0, 5'b00000, 0, 7'b0000101, 4'd1, 3'b111, "scsi_hold_last");
    add(0, 5'b00000, 0, 7'b0000101, 4'd1, 3'b000, "scsi_end");
    for (int i = 0; i < 2; i++)  add(0, 5'b00000, 1, 7'b0000011, 4'd0, 3'b100, "snd");
    add(0, 5'b00000, 1, 7'b0000001, 4'd0, 3'b000, "snd_off");

    foreach (vec_q[i]) begin
      drive(vec_q[i].bact, vec_q[i].cs, vec_q[i].snd_busy, vec_q[i].en, vec_q[i].timeout);
      tick();
      check(vec_q[i].name, outs(), vec_q[i].exp);
    end

    // Asynchronous reset while Cnt = 2 (timeout 3, five hold cycles elapsed).
    drive(1'b1, 5'b01000, 1'b0, 7'b0100000, 4'd3);
    tick();
    drive(1'b0, 5'b00000, 1'b0, 7'b0100000, 4'd3);
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_hold", outs(), 3'b101);
    #2 nPOR = 1'b0;
    #1 check("async_reset", outs(), 3'b000);
    #2 nPOR = 1'b1;
    tick();
    check("post_reset_idle", outs(), 3'b000);
    drive(1'b1, 5'b01000, 1'b0, 7'b0100000, 4'd3);
    tick();
    check("post_reset_hit", outs(), 3'b101);
    drive(1'b0, 5'b00000, 1'b0, 7'b0100000, 4'd0);
    tick();
    check("post_reset_t0_end", outs(), 3'b000);

    rehit(4'd2, "rehit_t2");
    rehit(4'd1, "rehit_t1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_window_ctl.md
Name: slow_window_ctl

Overview:
- Applies the slow-device settings written by the settings register to live bus traffic.
- On a CPU access to a device class whose Slow* bit is set, it asserts SlowReq, so the accelerator drops to Mac-speed timing, and optionally ClockGate.
- After the access ends it holds SlowReq for a programmable timeout window of SlowTimeout × TICK_DIV clocks.
- Sits between the settings register, the address decoder chip-selects and the CPU clock/speed switch.

Parameters:
- TICK_DIV, 256: clocks per timeout unit; prescaler period. Must be ≥ 2.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- nPOR  in  1  reset, asynchronous, active-low.
- BACT  in  1  bus access active; high for the full duration of a CPU bus cycle.
- IACKCS, VIACS, IWMCS, SCCCS, SCSICS  in  1 each  decoded device selects; valid whenever BACT is high.
- SndBusy  in  1  sound DMA in progress (level).
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate  in  1 each  per-class enables from the settings register.
- SlowTimeout  in  4  hold-window length in TICK_DIV units.
- SlowReq  out  1  request slow bus/CPU timing; registered.
- ClockGate  out  1  gate accelerator clock while slow; registered.
- SlowActive  out  1  FSM is not IDLE; registered.

Behaviour:
- Reset (nPOR low, asynchronous): FSM to IDLE. BACTr, Cnt, Pre, SlowReq, ClockGate and SlowActive all go to 0. Normal operation resumes on the first CLK edge after nPOR rises.
- BACTr is BACT registered each CLK.
- Start = BACT & ~BACTr (first cycle of an access).
- Hit = (IACKCS&SlowIACK) | (VIACS&SlowVIA) | (IWMCS&SlowIWM) | (SCCCS&SlowSCC) | (SCSICS&SlowSCSI). Hit is evaluated only in the Start cycle.
- FSM states: IDLE, SLOW, HOLD.
- IDLE:
  - Start & Hit → SLOW.
  - Otherwise stay in IDLE.
- SLOW:
  - Stay while BACT is high.
  - BACT low and SlowTimeout == 0 → IDLE.
  - BACT low and SlowTimeout != 0 → HOLD. On this edge load Cnt = SlowTimeout and Pre = TICK_DIV-1.
- HOLD:
  - Start & Hit → SLOW. Highest priority; the count is abandoned.
  - Otherwise, if Pre != 0: Pre decrements.
  - Otherwise, if Cnt == 1: → IDLE.
  - Otherwise: Cnt decrements and Pre reloads to TICK_DIV-1.
  - HOLD therefore lasts exactly SlowTimeout × TICK_DIV cycles when no new hit arrives.
- Accesses that are not hits during HOLD do not affect the count.
- SlowTimeout is sampled only at HOLD entry; changes during HOLD are ignored until the next entry.
- Changes to the Slow* enables take effect at the next Start.
- Outputs are registered from next-state, so they change on the same edge as the state:
  - SlowActive = (next state != IDLE).
  - SlowReq = (next state != IDLE) | (SndBusy & SlowSnd).
  - ClockGate = (next state != IDLE) & SlowClockGate.
- Latency: a hit Start sampled at edge k gives SlowReq = 1 after edge k, i.e. visible in cycle k+1.
- SndBusy does not alter the FSM. It only forces SlowReq, one-cycle registered.
- Back-to-back accesses with BACT never low (no Start) are treated as one access.
- Cnt is 4 bits and Pre is ceil(log2(TICK_DIV)) bits. Neither wraps: Cnt never decrements below 1, and Pre reloads at 0.

Test Plan:
- Reset mid-HOLD: assert nPOR low asynchronously while Cnt = 2 → all outputs 0 without waiting for CLK. After release, FSM is in IDLE.
- VIA hit, SlowVIA = 1, SlowTimeout = 3, TICK_DIV = 4, BACT high 5 cycles → SlowReq rises 1 cycle after the BACT rise, stays high 5 + 12 cycles, then falls. SlowActive tracks it.
- SCC access with SlowSCC = 0 and all other enables 1 → SlowReq stays 0, FSM stays IDLE.
- IWM hit with SlowTimeout = 0 → SlowReq falls on the edge after BACT falls; no HOLD cycles.
- Re-hit during HOLD: SlowTimeout = 2, TICK_DIV = 4, second IWM hit 5 cycles into HOLD → SLOW re-entered with no SlowReq gap, full 8-cycle HOLD after the second access. Repeat with SlowTimeout changed to 1 during the first HOLD → second HOLD is 4 cycles.
- Clock gate and sound: SlowClockGate = 1 with SCSI hit → ClockGate equals SlowReq throughout. Then IDLE with SndBusy = 1 and SlowSnd = 1 → SlowReq = 1, ClockGate = 0, SlowActive = 0. Then SlowSnd = 0 → SlowReq = 0.
